pulse_transmitter: RTL and testbench
====================================

Name: pulse_transmitter

Overview:
Generates the timing pulse that the wireless receiver's delay element later delays and compares against. It issues single-shot or continuous pulses with runtime-programmable width and period, both counted in clk cycles. It also emits a one-cycle tx_strobe coincident with each pulse rising edge, which the propagation-time meter uses as its start reference. A pulse counter supports cross-checking against received pulses.

Parameters:
CNT_W, 16, width of the width/period configuration inputs and internal cycle counter
PCOUNT_W, 16, width of the emitted-pulse counter
DEF_WIDTH, 130, pulse width in cycles used when width_cfg==0 (100 ns at 770 ps clk)
DEF_PERIOD, 15714, period in cycles used when period_cfg==0 (about 12.1 us)

Ports:
clk  input  1  system clock; all logic is on its rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  master enable; low blocks new pulses and stops continuous mode after the current cycle
continuous  input  1  1 = free-running pulse train; 0 = one pulse per start
start  input  1  level-sampled request; acted on only in IDLE
width_cfg  input  CNT_W  pulse high time in cycles; 0 selects DEF_WIDTH
period_cfg  input  CNT_W  rise-to-rise period in cycles; 0 selects DEF_PERIOD
pulse_out  output  1  registered transmit pulse
tx_strobe  output  1  one-cycle high on the cycle pulse_out first goes high
busy  output  1  high in PULSE or GAP
pulse_count  output  PCOUNT_W  number of pulses emitted since reset

Behaviour:
- Reset (rst high at a clk edge): state=IDLE; pulse_out=0, tx_strobe=0, busy=0, pulse_count=0; internal counter=0; latched width=DEF_WIDTH, latched period=DEF_PERIOD. Reset wins over all other inputs, including mid-pulse, and truncates the pulse immediately.
- States: IDLE, PULSE, GAP. All outputs are registered.
- IDLE -> PULSE at edge N when enable && (start || continuous). At edge N:
  - pulse_out<=1, tx_strobe<=1, busy<=1, pulse_count increments (wraps modulo 2^PCOUNT_W);
  - effective width W and period P are latched;
  - counter<=1.
- Config resolution at latch time:
  - W = width_cfg, or DEF_WIDTH if width_cfg==0.
  - P = period_cfg, or DEF_PERIOD if period_cfg==0.
  - If P <= W, force P = W+1 so at least one low cycle exists. If W = 2^CNT_W-1 so that W+1 overflows, clamp W to 2^CNT_W-2 and set P = 2^CNT_W-1.
  - Config changes outside the latch edge have no effect until the next latch.
- PULSE: pulse_out is high for exactly W cycles. When counter==W, go to GAP: pulse_out<=0, counter increments.
- GAP: pulse_out is low. When counter==P:
  - if continuous && enable: go to PULSE. This is a new rising edge with a fresh latch of W/P, tx_strobe pulses, pulse_count increments, and counter<=1. Rise-to-rise spacing is exactly P cycles.
  - otherwise: go to IDLE with busy<=0.
- tx_strobe is high for exactly one cycle per pulse and never high outside the first PULSE cycle.
- enable deasserted during PULSE or GAP does not truncate the current pulse or gap, so no runt pulses are produced. The block returns to IDLE at the end of GAP.
- start while busy is ignored (not queued). If start is held high in single-shot mode, the next pulse is issued on the first cycle in IDLE. The minimum single-shot rise-to-rise spacing is therefore P+1 cycles.
- continuous changing mid-cycle is sampled only at the GAP end decision.
- pulse_count wraps from 2^PCOUNT_W-1 to 0 with no flag.

Test Plan:
1. rst, then enable=1, continuous=0, width_cfg=4, period_cfg=10, start high for 1 cycle -> pulse_out high 4 cycles starting the cycle after start, low 6 cycles; tx_strobe 1 cycle aligned with the rise; pulse_count=1; busy for 10 cycles, then IDLE.
2. continuous=1, W=3, P=8, run for 40 cycles -> 5 pulses with rises exactly 8 cycles apart; pulse_count=5; tx_strobe count=5.
3. width_cfg=0, period_cfg=0 -> pulse_out high 130 cycles; next rise at 15714 cycles in continuous mode.
4. width_cfg=6, period_cfg=5 -> W=6, P=7: 6 high cycles, 1 low cycle; width_cfg=1, period_cfg=1 -> 1 high, 1 low.
5. Continuous W=4, P=10: drop enable at cycle 2 of PULSE -> full 4-cycle pulse plus 6-cycle gap, then IDLE with no further pulses; a start pulse during busy is ignored and pulse_count is unchanged.
6. Assert rst at cycle 2 of PULSE -> next cycle pulse_out=0, busy=0, pulse_count=0; force PCOUNT_W=2 and run 5 pulses -> pulse_count reads 1.

Source files
------------

// File: rtl/pulse_transmitter.sv
// ---------------------------------------------------------------------------
// pulse_transmitter
//
// Purpose:
//   Generates the timing pulse that the receiver's delay element later delays
//   and compares against. Issues single-shot or free-running pulses whose
//   width and rise-to-rise period are programmable at runtime in clk cycles.
//   A one-cycle tx_strobe marks every rising edge for the propagation-time
//   meter, and a wrapping pulse counter allows cross-checking against the
//   number of received pulses.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous active-high reset
//   enable       master enable; low blocks new pulses, never truncates one
//   continuous   1 = free-running pulse train, 0 = one pulse per start
//   start        level-sampled request, only acted on while idle
//   width_cfg    pulse high time in cycles (0 selects DEF_WIDTH)
//   period_cfg   rise-to-rise period in cycles (0 selects DEF_PERIOD)
//   pulse_out    registered transmit pulse
//   tx_strobe    one-cycle high on the first cycle of every pulse
//   busy         high while a pulse or its trailing gap is in progress
//   pulse_count  pulses emitted since reset, wraps silently
// ---------------------------------------------------------------------------
module pulse_transmitter #(
    parameter int CNT_W      = 16,
    parameter int PCOUNT_W   = 16,
    parameter int DEF_WIDTH  = 130,
    parameter int DEF_PERIOD = 15714
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                continuous,
    input  logic                start,
    input  logic [CNT_W-1:0]    width_cfg,
    input  logic [CNT_W-1:0]    period_cfg,
    output logic                pulse_out,
    output logic                tx_strobe,
    output logic                busy,
    output logic [PCOUNT_W-1:0] pulse_count
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_e;

    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]    DEF_W_C  = CNT_W'(DEF_WIDTH);
    localparam logic [CNT_W-1:0]    DEF_P_C  = CNT_W'(DEF_PERIOD);
    localparam logic [PCOUNT_W-1:0] PC_ONE   = PCOUNT_W'(1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      width_q, width_d;
    logic [CNT_W-1:0]      period_q, period_d;
    logic [PCOUNT_W-1:0]   pcount_q, pcount_d;
    logic                  pulse_q, pulse_d;
    logic                  strobe_q, strobe_d;
    logic                  busy_q, busy_d;

    logic                  launch;
    logic [CNT_W-1:0]      widthRaw, periodRaw;
    logic [CNT_W-1:0]      widthEff, periodEff;

    // Resolve the live configuration into the width/period that would be
    // latched on a rising edge. The period must always leave at least one
    // low cycle, and a maximal width is pulled down by one so that its
    // forced period still fits in the counter.
    always_comb begin
        widthRaw  = (width_cfg  == '0) ? DEF_W_C : width_cfg;
        periodRaw = (period_cfg == '0) ? DEF_P_C : period_cfg;
        widthEff  = widthRaw;
        periodEff = periodRaw;
        if (widthRaw == CNT_MAX) begin
            widthEff  = CNT_MAX - CNT_ONE;
            periodEff = CNT_MAX;
        end else if (periodRaw <= widthRaw) begin
            periodEff = widthRaw + CNT_ONE;
        end
    end

    // State register: every piece of state, including the registered
    // outputs, updates here. Reset truncates any pulse in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            width_q  <= DEF_W_C;
            period_q <= DEF_P_C;
            pcount_q <= '0;
            pulse_q  <= 1'b0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            period_q <= period_d;
            pcount_q <= pcount_d;
            pulse_q  <= pulse_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic. The counter runs 1..W through the high phase and
    // continues W+1..P through the gap, so a rise-to-rise period is exactly
    // P cycles when the train chains straight back into PULSE. A launch,
    // whether from IDLE or from the end of a gap, always re-latches W/P.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        width_d  = width_q;
        period_d = period_q;
        pcount_d = pcount_q;
        launch   = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && (start || continuous)) begin
                    launch = 1'b1;
                end
            end
            PULSE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == width_q) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == period_q) begin
                    if (continuous && enable) begin
                        launch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (launch) begin
            state_d  = PULSE;
            cnt_d    = CNT_ONE;
            width_d  = widthEff;
            period_d = periodEff;
            pcount_d = pcount_q + PC_ONE;
        end
    end

    // Output logic: next values of the registered outputs follow directly
    // from where the state machine is heading and whether it launches.
    always_comb begin
        pulse_d  = (state_d == PULSE);
        strobe_d = launch;
        busy_d   = (state_d != IDLE);
    end

    assign pulse_out   = pulse_q;
    assign tx_strobe   = strobe_q;
    assign busy        = busy_q;
    assign pulse_count = pcount_q;

endmodule

// File: tb/tb_pulse_transmitter.sv
// ---------------------------------------------------------------------------
// tb_pulse_transmitter
//
// Directed testbench for pulse_transmitter. A second instance with a 2-bit
// pulse counter shares the clock, reset and configuration and is only
// enabled for the counter-wrap scenario.
// ---------------------------------------------------------------------------
module tb_pulse_transmitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        continuous;
    logic        start;
    logic [15:0] widthCfg;
    logic [15:0] periodCfg;
    logic        pulseOut;
    logic        txStrobe;
    logic        busy;
    logic [15:0] pulseCount;

    logic        enable2;
    logic        start2;
    logic        pulseOut2;
    logic        txStrobe2;
    logic        busy2;
    logic [1:0]  pulseCount2;

    int compCount = 0;
    int failCount = 0;

    int hiCnt;
    int busyCnt;
    int stbCnt;
    int patErr;
    int secondRise;
    int busyAtK;

    pulse_transmitter #(
        .CNT_W(16), .PCOUNT_W(16), .DEF_WIDTH(130), .DEF_PERIOD(15714)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .continuous(continuous),
        .start(start), .width_cfg(widthCfg), .period_cfg(periodCfg),
        .pulse_out(pulseOut), .tx_strobe(txStrobe), .busy(busy),
        .pulse_count(pulseCount)
    );

    pulse_transmitter #(
        .CNT_W(16), .PCOUNT_W(2), .DEF_WIDTH(130), .DEF_PERIOD(15714)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .continuous(continuous),
        .start(start2), .width_cfg(widthCfg), .period_cfg(periodCfg),
        .pulse_out(pulseOut2), .tx_strobe(txStrobe2), .busy(busy2),
        .pulse_count(pulseCount2)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives the main instance's request and configuration inputs.
    task automatic applyStimulus(input logic en, input logic cont, input logic st,
                                 input logic [15:0] w, input logic [15:0] p);
        enable     = en;
        continuous = cont;
        start      = st;
        widthCfg   = w;
        periodCfg  = p;
    endtask

    // One reset edge with everything quiet; returns on the following negedge.
    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Clears the per-window accumulators.
    task automatic clearStats();
        hiCnt      = 0;
        busyCnt    = 0;
        stbCnt     = 0;
        patErr     = 0;
        secondRise = -1;
        busyAtK    = 0;
    endtask

    initial begin
        enable2 = 1'b0;
        start2  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        checkOutput("reset pulse_out", 32'(pulseOut), 32'd0);
        checkOutput("reset tx_strobe", 32'(txStrobe), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset pulse_count", 32'(pulseCount), 32'd0);
        checkOutput("reset pulse_count2", 32'(pulseCount2), 32'd0);

        // Single shot W=4, P=10; negedge k observes the state after edge k,
        // where edge 0 is the launch edge.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd4, 16'd10);
        @(negedge clk);
        start = 1'b0;
        clearStats();
        checkOutput("t1 first pulse_out", 32'(pulseOut), 32'd1);
        checkOutput("t1 first tx_strobe", 32'(txStrobe), 32'd1);
        for (int k = 0; k < 14; k++) begin
            hiCnt   += int'(pulseOut);
            busyCnt += int'(busy);
            stbCnt  += int'(txStrobe);
            if (pulseOut !== (k < 4))  patErr++;
            if (busy     !== (k < 10)) patErr++;
            if (txStrobe !== (k == 0)) patErr++;
            @(negedge clk);
        end
        checkOutput("t1 pattern errors", 32'(patErr), 32'd0);
        checkOutput("t1 high cycles", 32'(hiCnt), 32'd4);
        checkOutput("t1 busy cycles", 32'(busyCnt), 32'd10);
        checkOutput("t1 strobes", 32'(stbCnt), 32'd1);
        checkOutput("t1 pulse_count", 32'(pulseCount), 32'd1);

        // Continuous W=3, P=8 for 40 cycles, stopped at the last gap end.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, 16'd8);
        @(negedge clk);
        clearStats();
        for (int k = 0; k < 40; k++) begin
            hiCnt  += int'(pulseOut);
            stbCnt += int'(txStrobe);
            if (pulseOut !== ((k % 8) < 3))  patErr++;
            if (txStrobe !== ((k % 8) == 0)) patErr++;
            if (busy !== 1'b1) patErr++;
            if (k == 39) continuous = 1'b0;
            @(negedge clk);
        end
        checkOutput("t2 pattern errors", 32'(patErr), 32'd0);
        checkOutput("t2 high cycles", 32'(hiCnt), 32'd15);
        checkOutput("t2 strobes", 32'(stbCnt), 32'd5);
        checkOutput("t2 pulse_count", 32'(pulseCount), 32'd5);
        checkOutput("t2 idle after stop", 32'(busy), 32'd0);

        // Defaults: W=130, P=15714 in continuous mode.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
        @(negedge clk);
        clearStats();
        for (int k = 0; k <= 15714; k++) begin
            if (k < 15714) hiCnt += int'(pulseOut);
            if (txStrobe && k > 0 && secondRise < 0) secondRise = k;
            if (k == 15714) continuous = 1'b0;
            @(negedge clk);
        end
        checkOutput("t3 default width", 32'(hiCnt), 32'd130);
        checkOutput("t3 default period", 32'(secondRise), 32'd15714);
        checkOutput("t3 pulse_count", 32'(pulseCount), 32'd2);

        // W=6, P=5 forces P=7: six high cycles then one low cycle.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd6, 16'd5);
        @(negedge clk);
        start = 1'b0;
        clearStats();
        for (int k = 0; k < 10; k++) begin
            hiCnt   += int'(pulseOut);
            busyCnt += int'(busy);
            if (k == 6) busyAtK = int'(busy);
            if (pulseOut !== (k < 6)) patErr++;
            @(negedge clk);
        end
        checkOutput("t4 forced high cycles", 32'(hiCnt), 32'd6);
        checkOutput("t4 forced low cycle busy", 32'(busyAtK), 32'd1);
        checkOutput("t4 forced busy cycles", 32'(busyCnt), 32'd7);
        checkOutput("t4 forced pattern", 32'(patErr), 32'd0);

        // W=1, P=1 with start held: rises every P+1 = 3 cycles.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd1, 16'd1);
        @(negedge clk);
        clearStats();
        for (int k = 0; k < 7; k++) begin
            stbCnt += int'(txStrobe);
            if (txStrobe !== ((k % 3) == 0)) patErr++;
            if (pulseOut !== ((k % 3) == 0)) patErr++;
            if (busy     !== ((k % 3) != 2)) patErr++;
            if (k == 6) start = 1'b0;
            @(negedge clk);
        end
        checkOutput("t4 min pattern", 32'(patErr), 32'd0);
        checkOutput("t4 min strobes", 32'(stbCnt), 32'd3);
        checkOutput("t4 min pulse_count", 32'(pulseCount), 32'd3);

        // Continuous W=4, P=10 with enable dropped mid-pulse and a start
        // during busy: one whole pulse and gap, then nothing.
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd4, 16'd10);
        @(negedge clk);
        clearStats();
        for (int k = 0; k < 25; k++) begin
            hiCnt   += int'(pulseOut);
            busyCnt += int'(busy);
            stbCnt  += int'(txStrobe);
            if (pulseOut !== (k < 4))  patErr++;
            if (busy     !== (k < 10)) patErr++;
            if (k == 1) enable = 1'b0;
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            @(negedge clk);
        end
        checkOutput("t5 enable drop pattern", 32'(patErr), 32'd0);
        checkOutput("t5 enable drop high", 32'(hiCnt), 32'd4);
        checkOutput("t5 enable drop busy", 32'(busyCnt), 32'd10);
        checkOutput("t5 enable drop strobes", 32'(stbCnt), 32'd1);
        checkOutput("t5 enable drop count", 32'(pulseCount), 32'd1);

        // Single shot with start re-asserted while busy and enable high.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd4, 16'd10);
        @(negedge clk);
        start = 1'b0;
        clearStats();
        for (int k = 0; k < 25; k++) begin
            stbCnt += int'(txStrobe);
            if (busy !== (k < 10)) patErr++;
            if (k == 5) start = 1'b1;
            if (k == 6) start = 1'b0;
            @(negedge clk);
        end
        checkOutput("t5 busy start pattern", 32'(patErr), 32'd0);
        checkOutput("t5 busy start strobes", 32'(stbCnt), 32'd1);
        checkOutput("t5 busy start count", 32'(pulseCount), 32'd1);

        // Reset at the second pulse cycle truncates immediately.
        doReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 16'd4, 16'd10);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("t6 pulse before reset", 32'(pulseOut), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6 reset pulse_out", 32'(pulseOut), 32'd0);
        checkOutput("t6 reset busy", 32'(busy), 32'd0);
        checkOutput("t6 reset pulse_count", 32'(pulseCount), 32'd0);

        // Narrow counter: five pulses on the 2-bit instance wrap to 1.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'd1, 16'd2);
        enable2 = 1'b1;
        @(negedge clk);
        clearStats();
        for (int k = 0; k <= 8; k++) begin
            stbCnt += int'(txStrobe2);
            if (k == 8) begin
                checkOutput("t6 wrapped count", 32'(pulseCount2), 32'd1);
                continuous = 1'b0;
            end
            @(negedge clk);
        end
        @(negedge clk);
        checkOutput("t6 narrow strobes", 32'(stbCnt), 32'd5);
        checkOutput("t6 narrow idle", 32'(busy2), 32'd0);
        checkOutput("t6 narrow count held", 32'(pulseCount2), 32'd1);
        checkOutput("t6 main stayed idle", 32'(pulseCount), 32'd0);
        enable2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
